// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter
// Shares the single-port synchronous tape RAM between two pipeline stages.
// Each requester holds req (with we/addr/wdata stable) until it sees a
// one-cycle ack; reads additionally return a one-cycle drdy with rdata.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req0/1, we0/1        request and write-enable per port
//   addr0/1, wdata0/1    address and write data per port
//   ack0/1               request issued to RAM (one-cycle pulse)
//   drdy0/1, rdata0/1    read data valid pulse and held read data
//   mem_en, mem_we       RAM strobe and write enable
//   mem_addr, mem_wdata  RAM address and write data (held outside ISSUE)
//   mem_rdata            RAM read data, valid one cycle after mem_en
//
// Build option: define BF_ARB_FIXED_PRIO_EN to make port 0 win every
// conflict; otherwise conflicts are resolved round-robin.
module bf_mem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          drdy0,
   output logic          drdy1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } state_t;

   state_t r_state;
   logic   r_gnt;   // latched winner, selects which port receives read data
   logic   r_rd;    // latched op is a read

   // Winner of the current IDLE sample (1 = port 1).
   logic   w_win;

`ifdef BF_ARB_FIXED_PRIO_EN
   // Port 1 only wins when port 0 is not asking.
   assign w_win = req1 & ~req0;
`else
   logic   r_last;  // port that won most recently
   // On a conflict the port that did not win last time goes next.
   assign w_win = (req0 & req1) ? ~r_last : req1;
`endif

   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;

   assign w_we    = w_win ? we1    : we0;
   assign w_addr  = w_win ? addr1  : addr0;
   assign w_wdata = w_win ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 1'b0;
         r_rd      <= 1'b0;
`ifndef BF_ARB_FIXED_PRIO_EN
         r_last    <= 1'b1;
`endif
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         drdy0     <= 1'b0;
         drdy1     <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Pulses default low; mem_addr/mem_wdata/rdataN hold.
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         drdy0  <= 1'b0;
         drdy1  <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (req0 | req1) begin
                  r_state   <= ST_ISSUE;
                  r_gnt     <= w_win;
                  r_rd      <= ~w_we;
`ifndef BF_ARB_FIXED_PRIO_EN
                  r_last    <= w_win;
`endif
                  // Registered here so the RAM sees the access during ISSUE.
                  ack0      <= ~w_win;
                  ack1      <= w_win;
                  mem_en    <= 1'b1;
                  mem_we    <= w_we;
                  mem_addr  <= w_addr;
                  mem_wdata <= w_wdata;
               end
            end

            ST_ISSUE: begin
               r_state <= r_rd ? ST_DATA : ST_IDLE;
            end

            ST_DATA: begin
               // mem_rdata is valid now, one cycle after the strobe.
               r_state <= ST_IDLE;
               if (r_gnt) begin
                  rdata1 <= mem_rdata;
                  drdy1  <= 1'b1;
               end else begin
                  rdata0 <= mem_rdata;
                  drdy0  <= 1'b1;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
